// File: rtl/range_frame_sender.sv
// Purpose : buffers up to DEPTH host samples, then plays them out as one go/.../finish frame
//           and reports the consumer's range/error response back to the host.
// Latency : go with sample 0 two edges after start is sampled; result_valid one cycle after finish.
// Backpressure: load_ready drops while a frame is in flight or the buffer is full; writes
//           and start requests outside IDLE are dropped, never queued.
//
// Ports:
//   clock, reset_n                       rising-edge clock, async active-low reset
//   load_data/load_valid/load_ready      host sample write (valid/ready)
//   start, busy                          frame request (IDLE only), in-flight indicator
//   data_out, go, finish                 registered stream to the consumer
//   range_in, error_in                   consumer response
//   range_q, error_seen, result_valid    captured response, pulsed once per frame
//   count                                samples currently buffered
module range_frame_sender #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     start,
  output logic                     busy,
  output logic [WIDTH-1:0]         data_out,
  output logic                     go,
  output logic                     finish,
  input  logic [WIDTH-1:0]         range_in,
  input  logic                     error_in,
  output logic [WIDTH-1:0]         range_q,
  output logic                     error_seen,
  output logic                     result_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each state name matches what the registered stream outputs show while in it.
  // LOAD is the one-cycle launch slot between accepting start and presenting go.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRST,
    S_STREAM,
    S_FIN,
    S_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    frame_left;   // samples still to pop after the current one
  logic             wr_en;
  logic             pop;

  assign busy       = (state != S_IDLE);
  assign load_ready = (state == S_IDLE) && (count < CW'(DEPTH));
  assign wr_en      = load_valid && load_ready;

  // A pop happens on the edge that presents a sample: leaving LOAD presents sample 0,
  // leaving FIRST/STREAM presents the next one while any remain.
  assign pop = (state == S_LOAD) ||
               (((state == S_FIRST) || (state == S_STREAM)) && (frame_left != '0));

  // Sample storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      frame_left   <= '0;
      data_out     <= '0;
      go           <= 1'b0;
      finish       <= 1'b0;
      range_q      <= '0;
      error_seen   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      go           <= 1'b0;
      finish       <= 1'b0;
      result_valid <= 1'b0;
      data_out     <= '0;

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      // Writes are IDLE-only and pops are busy-only, so they never coincide.
      if (wr_en && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !wr_en) begin
        count <= count - CW'(1);
      end

      case (state)
        S_IDLE: begin
          // Frame length is the occupancy before any same-cycle write.
          if (start && (count != '0)) begin
            state      <= S_LOAD;
            frame_left <= count;
          end
        end
        S_LOAD: begin
          state      <= S_FIRST;
          go         <= 1'b1;
          frame_left <= frame_left - CW'(1);
          error_seen <= 1'b0;
        end
        S_FIRST, S_STREAM: begin
          error_seen <= error_seen | error_in;
          if (frame_left == '0) begin
            state  <= S_FIN;
            finish <= 1'b1;
          end else begin
            state      <= S_STREAM;
            frame_left <= frame_left - CW'(1);
          end
        end
        S_FIN: begin
          state        <= S_GAP;
          result_valid <= 1'b1;
          range_q      <= range_in;
          error_seen   <= error_seen | error_in;
        end
        S_GAP: begin
          // Guaranteed quiet cycle so the consumer can leave its finish state.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
